ysyx_25010008_icache: RTL and testbench
=======================================

Name: ysyx_25010008_icache

Overview:
- Direct-mapped, one-word-per-line, read-only instruction cache.
- Sits directly upstream of the IFU, between the IFU's AXI-lite read channel (slave side, s_*) and the system memory bus (master side, m_*).
- Hits return in 2 cycles with no bus traffic. Misses forward a single-beat read downstream and fill the line.
- fence_i invalidates all lines.

Parameters:
INDEX_BITS, 4, log2 of line count (16 lines of 32 bits)
RESET_VALID, 0, initial valid-bit value on reset (must stay 0 in product; bench only)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
s_arvalid  in  1  IFU read-address valid
s_arready  out  1  cache accepts address
s_araddr  in  32  fetch address (pc)
s_rvalid  out  1  instruction valid to IFU
s_rready  in  1  IFU accepts instruction
s_rdata  out  32  instruction word
s_rresp  out  2  0 = OKAY, otherwise forwarded bus error
m_arvalid  out  1  bus read-address valid
m_arready  in  1  bus accepts address
m_araddr  out  32  word-aligned miss address
m_rvalid  in  1  bus read data valid
m_rready  out  1  cache accepts bus data
m_rdata  in  32  bus read data
m_rresp  in  2  bus response
fence_i  in  1  one-cycle pulse: invalidate all lines
hit_cnt  out  32  wrapping hit counter
miss_cnt  out  32  wrapping miss counter

Behaviour:
- Address split:
  - index = addr[INDEX_BITS+1:2]
  - tag = addr[31:INDEX_BITS+2]
  - addr[1:0] ignored; m_araddr has [1:0] = 0.
- Storage: valid[2^INDEX_BITS], tag and data arrays, all flops. Valid bits are resettable.
- Reset values:
  - state = IDLE
  - s_rvalid = 0, s_rresp = 0, m_arvalid = 0, m_rready = 0
  - all valid bits = RESET_VALID, counters = 0
  - s_arready = 1 (decoded from state == IDLE)
  - s_rdata and m_araddr: don't-care.
- States:
  - IDLE: s_arready = 1. On s_arvalid, latch addr and go to LOOKUP.
  - LOOKUP: compare valid[index] and tag.
    - Hit: load s_rdata from array, s_rresp = 0, s_rvalid <= 1, hit_cnt++, go to RESP.
    - Miss: m_arvalid <= 1, m_araddr <= latched addr, miss_cnt++, go to MISS_AR.
  - MISS_AR: hold m_arvalid and m_araddr stable until m_arready. On handshake, m_arvalid <= 0, m_rready <= 1, go to MISS_R.
  - MISS_R: on m_rvalid, m_rready <= 0, s_rdata <= m_rdata, s_rresp <= m_rresp, s_rvalid <= 1, go to RESP.
    - If m_rresp == 0, write tag/data and set valid[index].
    - If m_rresp != 0, the line is not filled.
  - RESP: hold s_rvalid, s_rdata and s_rresp stable until s_rready. On handshake, s_rvalid <= 0, go to IDLE.
- Latency:
  - Hit: s_arvalid accept in cycle 0, s_rvalid in cycle 2.
  - Miss: 2 cycles plus bus latency.
- Back-to-back: a new address is accepted only in IDLE. After the s_r handshake, the earliest next accept is the following cycle.
- fence_i:
  - Clears all valid bits in the cycle it is sampled, in any state.
  - Same cycle as a MISS_R fill: the invalidate wins and the line stays invalid. The data is still returned to the IFU.
  - Same cycle as a LOOKUP hit: the hit stands, using the pre-clear contents.
- Reset mid-operation: all state returns to IDLE immediately and any outstanding bus transaction is abandoned. The bus is reset by the same signal.
- Counters wrap at 2^32.

Decomposition:
- Shared package ysyx_25010008_pkg holds:
  - state encoding (IDLE/LOOKUP/MISS_AR/MISS_R/RESP)
  - AXI resp codes (OKAY = 0, SLVERR = 2, DECERR = 3)
  - reset PC 0x3000_0000
- One sub-module, ysyx_25010008_icache_array: valid/tag/data storage with combinational read by index, a synchronous write port, and flash-clear on fence_i and reset.

Test Plan:
- Cold miss: reset, fetch 0x3000_0000; bus returns 0x00000413 after 3 cycles. Required: one m_ar handshake at m_araddr = 0x3000_0000, s_rdata = 0x00000413, s_rresp = 0, miss_cnt = 1.
- Hit: re-fetch 0x3000_0000. Required: s_rvalid 2 cycles after the accept, no m_arvalid, s_rdata = 0x00000413, hit_cnt = 1.
- Conflict: fetch 0x3000_0040 (same index 0, INDEX_BITS = 4), then 0x3000_0000. Required: both miss (miss_cnt += 2), m_araddr values 0x3000_0040 then 0x3000_0000.
- Error/backpressure: bus returns m_rresp = 2, and s_rready is held 0 for 5 cycles. Required: s_rvalid, s_rdata and s_rresp = 2 stable throughout; a re-fetch of the same address misses again.
- fence_i: after the hit test, pulse fence_i. Fetch 0x3000_0000. Required: miss. Also, fence_i asserted in the same cycle as m_rvalid leaves the line invalid, so the next fetch misses.
- Reset mid-miss: assert reset (0) while in MISS_R. Required: s_rvalid = 0, m_rready = 0, s_arready = 1, counters = 0, and the next fetch misses.

Source files
------------

// File: rtl/ysyx_25010008_icache_pkg.sv
// Shared definitions for the instruction cache slice.
// Holds bus widths, the controller state encoding, AXI response codes,
// the read-beat payload struct and the core reset PC.
package ysyx_25010008_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RESP_W = 2;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_MISS_AR = 3'd2,
        S_MISS_R  = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'd0;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'd2;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'd3;

    localparam logic [ADDR_W-1:0] RESET_PC = 32'h3000_0000;

    // One read-data beat as returned to the IFU.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [RESP_W-1:0] resp;
    } rbeat_t;

endpackage

// File: rtl/ysyx_25010008_icache_if.sv
// AXI-lite read channel (AR + R) bundle.
// master: drives arvalid/araddr/rready; slave: drives arready/rvalid/rdata/rresp.
interface ysyx_25010008_icache_if;
    import ysyx_25010008_pkg::*;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [RESP_W-1:0] rresp;

    modport master (output arvalid, araddr, rready, input arready, rvalid, rdata, rresp);
    modport slave  (input arvalid, araddr, rready, output arready, rvalid, rdata, rresp);

endinterface

// File: rtl/ysyx_25010008_icache_array.sv
// Line storage for the direct-mapped icache: valid/tag/data flops.
// Ports: clock/reset; i_clear flash-invalidates all lines; i_rd_index gives
// a combinational read (o_rd_valid/o_rd_tag/o_rd_data); i_we with
// i_wr_index/i_wr_tag/i_wr_data fills one line on the clock edge.
module ysyx_25010008_icache_array
    import ysyx_25010008_pkg::*;
#(
    parameter  int unsigned INDEX_BITS  = 4,
    parameter  bit          RESET_VALID = 1'b0,
    localparam int unsigned TAG_W       = ADDR_W - INDEX_BITS - 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    output logic                  o_rd_valid,
    output logic [TAG_W-1:0]      o_rd_tag,
    output logic [DATA_W-1:0]     o_rd_data,
    input  logic                  i_we,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_W-1:0]      i_wr_tag,
    input  logic [DATA_W-1:0]     i_wr_data
);

    localparam int unsigned LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    // Valid bits: a clear in the same cycle as a fill leaves the line invalid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= {LINES{RESET_VALID}};
        end else if (i_clear) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag/data payload; contents are meaningless while the valid bit is clear.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/ysyx_25010008_icache.sv
// Direct-mapped, one-word-per-line, read-only instruction cache.
// Ports: clock/reset (async, active low); s_bus = IFU-facing AXI-lite read
// slave; m_bus = memory-facing AXI-lite read master; fence_i invalidates all
// lines; hit_cnt/miss_cnt are wrapping event counters.
module ysyx_25010008_icache
    import ysyx_25010008_pkg::*;
#(
    parameter int unsigned INDEX_BITS  = 4,
    parameter bit          RESET_VALID = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    ysyx_25010008_icache_if.slave  s_bus,
    ysyx_25010008_icache_if.master m_bus,
    input  logic                  fence_i,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt
);

    localparam int unsigned TAG_W   = ADDR_W - INDEX_BITS - 2;
    localparam int unsigned IDX_LSB = 2;

    state_t                    r_state, w_state_nxt;
    logic [ADDR_W-1:IDX_LSB]   r_addr, w_addr_nxt;
    logic                      r_srvalid, w_srvalid_nxt;
    rbeat_t                    r_sbeat, w_sbeat_nxt;
    logic                      r_marvalid, w_marvalid_nxt;
    logic                      r_mrready, w_mrready_nxt;
    logic [CNT_W-1:0]          r_hit_cnt, w_hit_cnt_nxt;
    logic [CNT_W-1:0]          r_miss_cnt, w_miss_cnt_nxt;
    logic                      w_fill;

    logic [INDEX_BITS-1:0]     w_index;
    logic [TAG_W-1:0]          w_tag;
    logic                      w_rd_valid;
    logic [TAG_W-1:0]          w_rd_tag;
    logic [DATA_W-1:0]         w_rd_data;
    logic                      w_hit;
    logic                      w_unused_lsb;

    assign w_index = r_addr[INDEX_BITS+1:IDX_LSB];
    assign w_tag   = r_addr[ADDR_W-1:INDEX_BITS+2];
    assign w_hit   = w_rd_valid && (w_rd_tag == w_tag);

    // Byte offset of the fetch address is irrelevant to a word cache.
    assign w_unused_lsb = ^s_bus.araddr[IDX_LSB-1:0];

    ysyx_25010008_icache_array #(
        .INDEX_BITS  (INDEX_BITS),
        .RESET_VALID (RESET_VALID)
    ) u_array (
        .clock      (clock),
        .reset      (reset),
        .i_clear    (fence_i),
        .i_rd_index (w_index),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_we       (w_fill),
        .i_wr_index (w_index),
        .i_wr_tag   (w_tag),
        .i_wr_data  (m_bus.rdata)
    );

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_srvalid  <= 1'b0;
            r_sbeat    <= '0;
            r_marvalid <= 1'b0;
            r_mrready  <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_srvalid  <= w_srvalid_nxt;
            r_sbeat    <= w_sbeat_nxt;
            r_marvalid <= w_marvalid_nxt;
            r_mrready  <= w_mrready_nxt;
            r_hit_cnt  <= w_hit_cnt_nxt;
            r_miss_cnt <= w_miss_cnt_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_srvalid_nxt  = r_srvalid;
        w_sbeat_nxt    = r_sbeat;
        w_marvalid_nxt = r_marvalid;
        w_mrready_nxt  = r_mrready;
        w_hit_cnt_nxt  = r_hit_cnt;
        w_miss_cnt_nxt = r_miss_cnt;
        w_fill         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (s_bus.arvalid) begin
                    w_addr_nxt  = s_bus.araddr[ADDR_W-1:IDX_LSB];
                    w_state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    w_sbeat_nxt.data = w_rd_data;
                    w_sbeat_nxt.resp = RESP_OKAY;
                    w_srvalid_nxt    = 1'b1;
                    w_hit_cnt_nxt    = r_hit_cnt + CNT_W'(1);
                    w_state_nxt      = S_RESP;
                end else begin
                    w_marvalid_nxt = 1'b1;
                    w_miss_cnt_nxt = r_miss_cnt + CNT_W'(1);
                    w_state_nxt    = S_MISS_AR;
                end
            end
            S_MISS_AR: begin
                if (m_bus.arready) begin
                    w_marvalid_nxt = 1'b0;
                    w_mrready_nxt  = 1'b1;
                    w_state_nxt    = S_MISS_R;
                end
            end
            S_MISS_R: begin
                if (m_bus.rvalid) begin
                    w_mrready_nxt    = 1'b0;
                    w_sbeat_nxt.data = m_bus.rdata;
                    w_sbeat_nxt.resp = m_bus.rresp;
                    w_srvalid_nxt    = 1'b1;
                    // Errored beats are forwarded but never cached.
                    w_fill           = (m_bus.rresp == RESP_OKAY);
                    w_state_nxt      = S_RESP;
                end
            end
            S_RESP: begin
                if (s_bus.rready) begin
                    w_srvalid_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign s_bus.arready = (r_state == S_IDLE);
    assign s_bus.rvalid  = r_srvalid;
    assign s_bus.rdata   = r_sbeat.data;
    assign s_bus.rresp   = r_sbeat.resp;
    assign m_bus.arvalid = r_marvalid;
    assign m_bus.araddr  = {r_addr, 2'b00};
    assign m_bus.rready  = r_mrready;
    assign hit_cnt       = r_hit_cnt;
    assign miss_cnt      = r_miss_cnt;

endmodule

// File: tb/tb_ysyx_25010008_icache.sv
// Self-checking bench for ysyx_25010008_icache: directed scenarios plus a
// randomized fetch stream compared against a line-level cache model.
module tb_ysyx_25010008_icache;
    import ysyx_25010008_pkg::*;

    logic        clock;
    logic        reset;
    logic        fence_i, fence_tb, fence_bus;
    logic [31:0] hit_cnt, miss_cnt;

    ysyx_25010008_icache_if s_if ();
    ysyx_25010008_icache_if m_if ();

    assign fence_i = fence_tb | fence_bus;

    ysyx_25010008_icache #(.INDEX_BITS(4), .RESET_VALID(1'b0)) dut (
        .clock    (clock),
        .reset    (reset),
        .s_bus    (s_if),
        .m_bus    (m_if),
        .fence_i  (fence_i),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    bit          mv [16];
    logic [31:0] mt [16];
    logic [31:0] md [16];
    logic [31:0] m_hits, m_misses;

    logic [31:0] err_addr = 32'h0000_0001;  // unaligned: never matches a word
    logic [1:0]  err_resp = 2'd2;
    int          bus_lat  = 1;
    bit          fence_on_rvalid = 0;
    logic [31:0] ar_log [$];

    function automatic logic [31:0] bus_word(input logic [31:0] a);
        if (a == RESET_PC) return 32'h0000_0413;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [1:0] bus_resp(input logic [31:0] a);
        return (a == err_addr) ? err_resp : 2'd0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mv[i] = 0;
        m_hits = 0;
        m_misses = 0;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) mv[i] = 0;
    endfunction

    // One fetch through the model: returns hit flag and the word the IFU must see.
    function automatic void model_access(input logic [31:0] addr, input bit fence_lookup,
                                         input bit fence_fill, output bit hit,
                                         output logic [31:0] data, output logic [1:0] resp);
        logic [31:0] w;
        int i;
        w = addr & ~32'h3;
        i = int'((w / 4) % 16);
        hit = mv[i] && (mt[i] == (w >> 6));
        if (hit) begin
            data = md[i]; resp = 2'd0; m_hits = m_hits + 1;
        end else begin
            data = bus_word(w); resp = bus_resp(w); m_misses = m_misses + 1;
        end
        if (fence_lookup) model_clear();
        if (!hit) begin
            if (fence_fill) model_clear();
            else if (resp == 2'd0) begin mv[i] = 1; mt[i] = w >> 6; md[i] = w == w ? data : data; end
        end
    endfunction

    // ---------------- clock and bus responder ----------------
    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        int          bst, cnt;
        bit          ar_hs, r_hs;
        logic [31:0] ar_a, cur;
        bst = 0; cnt = 0; cur = 0;
        m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = 0; m_if.rresp = 0;
        fence_bus = 0;
        forever begin
            @(negedge clock);
            ar_hs = m_if.arvalid && m_if.arready;
            r_hs  = m_if.rvalid && m_if.rready;
            ar_a  = m_if.araddr;
            @(posedge clock); #1;
            fence_bus = 0;
            if (!reset) begin
                bst = 0; m_if.rvalid = 0; m_if.arready = 0;
                continue;
            end
            m_if.arready = ($urandom_range(0, 3) != 0);
            if (bst == 2 && r_hs) begin
                m_if.rvalid = 0; bst = 0;
            end else if (bst == 0 && ar_hs) begin
                ar_log.push_back(ar_a); cur = ar_a; cnt = bus_lat; bst = 1;
            end
            if (bst == 1) begin
                if (cnt == 0) begin
                    m_if.rvalid = 1; m_if.rdata = bus_word(cur); m_if.rresp = bus_resp(cur);
                    if (fence_on_rvalid) fence_bus = 1;
                    bst = 2;
                end else cnt--;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus driver ----------------
    // Issues one fetch and reports what the IFU observed; all checks are done by callers.
    task automatic fetch(input logic [31:0] addr, input int hold, input bit fence_lookup,
                         output logic [31:0] rdata, output logic [1:0] rresp, output int lat,
                         output int n_ar, output logic [31:0] ar_addr, output bit ok,
                         output bit stable);
        int n0, w;
        n0 = ar_log.size(); ok = 1; stable = 1; lat = 0; w = 0;
        rdata = 0; rresp = 0; ar_addr = 0;
        while (s_if.arready !== 1'b1 && w < 50) begin @(posedge clock); #1; w++; end
        s_if.arvalid = 1; s_if.araddr = addr; s_if.rready = 0;
        @(posedge clock); #1;
        s_if.arvalid = 0;
        if (fence_lookup) fence_tb = 1;
        lat = 1;
        while (s_if.rvalid !== 1'b1 && lat < 200) begin
            @(posedge clock); #1; fence_tb = 0; lat++;
        end
        fence_tb = 0;
        if (lat >= 200) begin ok = 0; n_ar = ar_log.size() - n0; return; end
        rdata = s_if.rdata; rresp = s_if.rresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            if (s_if.rvalid !== 1'b1 || s_if.rdata !== rdata || s_if.rresp !== rresp) stable = 0;
        end
        s_if.rready = 1;
        @(posedge clock); #1;
        s_if.rready = 0;
        if (s_if.rvalid !== 1'b0) stable = 0;
        n_ar = ar_log.size() - n0;
        if (n_ar > 0) ar_addr = ar_log[$];
    endtask

    task automatic pulse_fence();
        fence_tb = 1; @(posedge clock); #1; fence_tb = 0;
        model_clear();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 0; fence_tb = 0;
        s_if.arvalid = 0; s_if.araddr = 0; s_if.rready = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #1; reset = 1;
        @(negedge clock);
        n_vec++; if (s_if.arready !== 1'b1) begin n_err++; $display("FAIL reset_arready: got %b want 1", s_if.arready); end
        n_vec++; if (s_if.rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b want 0", s_if.rvalid); end
        n_vec++; if (s_if.rresp !== 2'd0) begin n_err++; $display("FAIL reset_rresp: got %0d want 0", s_if.rresp); end
        n_vec++; if (m_if.arvalid !== 1'b0) begin n_err++; $display("FAIL reset_m_arvalid: got %b want 0", m_if.arvalid); end
        n_vec++; if (m_if.rready !== 1'b0) begin n_err++; $display("FAIL reset_m_rready: got %b want 0", m_if.rready); end
        n_vec++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin n_err++; $display("FAIL reset_counters: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
        @(posedge clock); #1;
    endtask

    task automatic test_cold_miss_and_hit();
        logic [31:0] d, a, ed; logic [1:0] r, er; int lat, n; bit ok, st, h;
        bus_lat = 3;
        model_access(RESET_PC, 0, 0, h, ed, er);
        fetch(RESET_PC, 0, 0, d, r, lat, n, a, ok, st);
        n_vec++; if (!ok || n !== 1) begin n_err++; $display("FAIL cold_ar_count: got %0d want 1 (ok=%0d)", n, ok); end
        n_vec++; if (a !== 32'h3000_0000) begin n_err++; $display("FAIL cold_araddr: got %h want 30000000", a); end
        n_vec++; if (d !== 32'h0000_0413 || r !== 2'd0) begin n_err++; $display("FAIL cold_data: got %h/%0d want 00000413/0", d, r); end
        n_vec++; if (miss_cnt !== 32'd1) begin n_err++; $display("FAIL cold_miss_cnt: got %0d want 1", miss_cnt); end
        // Low address bits must be ignored on the hit path.
        model_access(RESET_PC + 2, 0, 0, h, ed, er);
        fetch(RESET_PC + 2, 0, 0, d, r, lat, n, a, ok, st);
        n_vec++; if (!ok || n !== 0) begin n_err++; $display("FAIL hit_bus_traffic: got %0d ar want 0", n); end
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL hit_latency: got %0d want 2", lat); end
        n_vec++; if (d !== ed || d !== 32'h0000_0413) begin n_err++; $display("FAIL hit_data: got %h want 00000413", d); end
        n_vec++; if (hit_cnt !== 32'd1) begin n_err++; $display("FAIL hit_cnt: got %0d want 1", hit_cnt); end
    endtask

    task automatic test_fence();
        logic [31:0] d, a, ed; logic [1:0] r, er; int lat, n; bit ok, st, h;
        pulse_fence();
        model_access(RESET_PC, 0, 0, h, ed, er);
        fetch(RESET_PC, 0, 0, d, r, lat, n, a, ok, st);
        n_vec++; if (!ok || n !== 1 || h) begin n_err++; $display("FAIL fence_miss: got %0d ar want 1", n); end
        n_vec++; if (d !== 32'h0000_0413) begin n_err++; $display("FAIL fence_data: got %h want 00000413", d); end
        // Invalidate coinciding with the fill beat: data returned, line not kept.
        fence_on_rvalid = 1;
        model_access(RESET_PC + 4, 0, 1, h, ed, er);
        fetch(RESET_PC + 4, 0, 0, d, r, lat, n, a, ok, st);
        fence_on_rvalid = 0;
        n_vec++; if (!ok || n !== 1 || d !== ed) begin n_err++; $display("FAIL fence_fill_data: got %h want %h", d, ed); end
        model_access(RESET_PC + 4, 0, 0, h, ed, er);
        fetch(RESET_PC + 4, 0, 0, d, r, lat, n, a, ok, st);
        n_vec++; if (!ok || n !== 1) begin n_err++; $display("FAIL fence_fill_refetch: got %0d ar want 1", n); end
        n_vec++; if (hit_cnt !== m_hits || miss_cnt !== m_misses) begin n_err++; $display("FAIL fence_counters: got %0d/%0d want %0d/%0d", hit_cnt, miss_cnt, m_hits, m_misses); end
    endtask

    task automatic test_conflict();
        logic [31:0] d, a, ed; logic [1:0] r, er; int lat, n; bit ok, st, h;
        logic [31:0] m0;
        m0 = miss_cnt;
        model_access(32'h3000_0040, 0, 0, h, ed, er);
        fetch(32'h3000_0040, 0, 0, d, r, lat, n, a, ok, st);
        n_vec++; if (!ok || n !== 1 || a !== 32'h3000_0040) begin n_err++; $display("FAIL conflict_first: got %0d ar @%h want 1 @30000040", n, a); end
        n_vec++; if (d !== ed) begin n_err++; $display("FAIL conflict_first_data: got %h want %h", d, ed); end
        model_access(32'h3000_0000, 0, 0, h, ed, er);
        fetch(32'h3000_0000, 0, 0, d, r, lat, n, a, ok, st);
        n_vec++; if (!ok || n !== 1 || a !== 32'h3000_0000) begin n_err++; $display("FAIL conflict_second: got %0d ar @%h want 1 @30000000", n, a); end
        n_vec++; if (miss_cnt !== m0 + 32'd2) begin n_err++; $display("FAIL conflict_miss_cnt: got %0d want %0d", miss_cnt, m0 + 32'd2); end
    endtask

    task automatic test_error_backpressure();
        logic [31:0] d, a, ed; logic [1:0] r, er; int lat, n; bit ok, st, h;
        err_addr = 32'h3000_0100; err_resp = RESP_SLVERR;
        model_access(32'h3000_0100, 0, 0, h, ed, er);
        fetch(32'h3000_0100, 5, 0, d, r, lat, n, a, ok, st);
        n_vec++; if (!ok || r !== 2'd2 || d !== ed) begin n_err++; $display("FAIL err_resp: got %h/%0d want %h/2", d, r, ed); end
        n_vec++; if (!st) begin n_err++; $display("FAIL err_backpressure_stable: got unstable want stable"); end
        model_access(32'h3000_0100, 0, 0, h, ed, er);
        fetch(32'h3000_0100, 0, 0, d, r, lat, n, a, ok, st);
        n_vec++; if (!ok || n !== 1 || r !== 2'd2) begin n_err++; $display("FAIL err_refetch_miss: got %0d ar resp %0d want 1 ar resp 2", n, r); end
        err_addr = 32'h0000_0001;
    endtask

    task automatic test_reset_mid_miss();
        logic [31:0] d, a, ed; logic [1:0] r, er; int lat, n, w; bit ok, st, h;
        bus_lat = 10;
        w = 0;
        s_if.arvalid = 1; s_if.araddr = 32'h3000_0200;
        @(posedge clock); #1;
        s_if.arvalid = 0;
        while (m_if.rready !== 1'b1 && w < 50) begin @(posedge clock); #1; w++; end
        n_vec++; if (w >= 50) begin n_err++; $display("FAIL rst_mid_reach_miss_r: got timeout want m_rready"); end
        reset = 0;
        #1;
        n_vec++; if (s_if.rvalid !== 1'b0 || m_if.rready !== 1'b0) begin n_err++; $display("FAIL rst_mid_outputs: got rvalid=%b rready=%b want 0/0", s_if.rvalid, m_if.rready); end
        n_vec++; if (s_if.arready !== 1'b1) begin n_err++; $display("FAIL rst_mid_arready: got %b want 1", s_if.arready); end
        n_vec++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin n_err++; $display("FAIL rst_mid_counters: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
        repeat (2) @(posedge clock);
        #1; reset = 1;
        model_reset();
        bus_lat = 2;
        model_access(RESET_PC, 0, 0, h, ed, er);
        fetch(RESET_PC, 0, 0, d, r, lat, n, a, ok, st);
        n_vec++; if (!ok || n !== 1 || miss_cnt !== 32'd1) begin n_err++; $display("FAIL rst_mid_next_miss: got %0d ar cnt %0d want 1/1", n, miss_cnt); end
    endtask

    task automatic test_random();
        logic [31:0] d, a, ed, addr; logic [1:0] r, er; int lat, n; bit ok, st, h, fl, ff;
        for (int it = 0; it < 80; it++) begin
            addr = 32'h3000_0000 + (32'($urandom_range(0, 2)) << 6)
                 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                err_addr = addr & ~32'h3;
                err_resp = ($urandom_range(0, 1) != 0) ? RESP_SLVERR : RESP_DECERR;
            end else err_addr = 32'h0000_0001;
            if ($urandom_range(0, 9) == 0) pulse_fence();
            fl = ($urandom_range(0, 7) == 0);
            ff = ($urandom_range(0, 7) == 0);
            bus_lat = $urandom_range(0, 3);
            fence_on_rvalid = ff;
            model_access(addr, fl, ff, h, ed, er);
            fetch(addr, $urandom_range(0, 3), fl, d, r, lat, n, a, ok, st);
            fence_on_rvalid = 0;
            n_vec++; if (!ok || n !== (h ? 0 : 1)) begin n_err++; $display("FAIL rand_hitmiss[%0d]: got %0d ar want %0d addr %h", it, n, h ? 0 : 1, addr); end
            n_vec++; if (d !== ed || r !== er) begin n_err++; $display("FAIL rand_data[%0d]: got %h/%0d want %h/%0d", it, d, r, ed, er); end
            n_vec++; if (!st) begin n_err++; $display("FAIL rand_stable[%0d]: got unstable want stable", it); end
            if (h) begin
                n_vec++; if (lat !== 2) begin n_err++; $display("FAIL rand_hit_lat[%0d]: got %0d want 2", it, lat); end
            end else begin
                n_vec++; if (a !== (addr & ~32'h3)) begin n_err++; $display("FAIL rand_araddr[%0d]: got %h want %h", it, a, addr & ~32'h3); end
            end
            n_vec++; if (hit_cnt !== m_hits || miss_cnt !== m_misses) begin n_err++; $display("FAIL rand_counters[%0d]: got %0d/%0d want %0d/%0d", it, hit_cnt, miss_cnt, m_hits, m_misses); end
        end
        err_addr = 32'h0000_0001;
    endtask

    initial begin
        test_reset();
        test_cold_miss_and_hit();
        test_fence();
        test_conflict();
        test_error_backpressure();
        test_reset_mid_miss();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
